// File: rtl/seq_stream_tx.sv
// Serial bit-stream transmitter: loads a word through a valid/ready handshake,
// shifts it out LSB-first on bit_en strobes and counts overlapping "000" windows.
module seq_stream_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [LEN_W-1:0] zero_runs
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       z_q, z_d;
    logic [LEN_W-1:0] zruns_q, zruns_d;
    logic [LEN_W-1:0] eff_len;

    // Zero or oversized lengths fall back to a full word.
    assign eff_len = ((load_len == '0) || (load_len > WIDTH_L)) ? WIDTH_L : load_len;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        z_d     = z_q;
        zruns_d = zruns_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    shift_d = load_data;
                    rem_d   = eff_len;
                    z_d     = 2'd0;
                    zruns_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_en) begin
                    shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    rem_d   = rem_q - ONE_L;
                    if (shift_q[0]) begin
                        z_d = 2'd0;
                    end else begin
                        if (z_q == 2'd2) begin
                            zruns_d = zruns_q + ONE_L;
                        end
                        z_d = (z_q == 2'd2) ? 2'd2 : z_q + 2'd1;
                    end
                    if (rem_q == ONE_L) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            z_q     <= 2'd0;
            zruns_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            z_q     <= z_d;
            zruns_q <= zruns_d;
        end
    end

    assign load_ready = (state_q == S_IDLE);
    assign ser_valid  = (state_q == S_SEND);
    assign ser_out    = (state_q == S_SEND) ? shift_q[0] : 1'b1;
    assign done       = (state_q == S_DONE);
    assign zero_runs  = zruns_q;

endmodule

// File: tb/tb_seq_stream_tx.sv
// Self-checking bench for seq_stream_tx: queue-based reference model checked
// every cycle, plus directed words with hand-computed expectations.
module tb_seq_stream_tx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic             bit_en = 1'b0;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic [LEN_W-1:0] zero_runs;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    seq_stream_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .bit_en     (bit_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .done       (done),
        .zero_runs  (zero_runs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending bits of the word, bits already consumed, and a done flag.
    bit q_bits[$];
    bit consumed[$];
    bit m_done = 1'b0;
    int m_zr = 0;

    function automatic int count_windows();
        int n = 0;
        for (int i = 2; i < consumed.size(); i++)
            if (!consumed[i] && !consumed[i-1] && !consumed[i-2]) n++;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_bits.delete();
            consumed.delete();
            m_done = 1'b0;
            m_zr = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (q_bits.size() > 0) begin
            if (bit_en) begin
                consumed.push_back(q_bits.pop_front());
                m_zr = count_windows();
                if (q_bits.size() == 0) m_done = 1'b1;
            end
        end else if (load_valid) begin
            int n;
            n = (load_len == 0 || int'(load_len) > WIDTH) ? WIDTH : int'(load_len);
            consumed.delete();
            m_zr = 0;
            for (int i = 0; i < n; i++) q_bits.push_back(load_data[i]);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit idle;
            idle = (q_bits.size() == 0) && !m_done;
            check("load_ready", 32'(load_ready), 32'(idle));
            check("ser_valid", 32'(ser_valid), 32'(q_bits.size() > 0));
            check("ser_out", 32'(ser_out), (q_bits.size() > 0) ? 32'(q_bits[0]) : 32'd1);
            check("done", 32'(done), 32'(m_done));
            check("zero_runs", 32'(zero_runs), 32'(m_zr));
        end
    end

    // Sends one word with bit_en tied high; returns emitted bits (LSB first) and the done cycle.
    task automatic send_word(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len,
                             output logic [31:0] bits, output int nb, output int done_cyc);
        bits = '0;
        nb = 0;
        done_cyc = -1;
        @(negedge clk);
        load_valid = 1'b1;
        load_data = data;
        load_len = len;
        bit_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                done_cyc = c;
                check("ready_low_in_done", 32'(load_ready), 32'd0);
                break;
            end
            if (ser_valid) begin
                bits[nb] = ser_out;
                nb++;
            end
            @(negedge clk);
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done pulse within 100 cycles");
        end else begin
            @(negedge clk);
            check("ready_after_done", 32'(load_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] bits;
        int nb, dc, cnt, c_second;
        bit seen_done;

        // Mid-cycle asynchronous reset must force idle outputs immediately.
        #2 rst = 1'b0;
        #1;
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_ser_out", 32'(ser_out), 32'd1);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero_runs", 32'(zero_runs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        send_word(16'b0101011101111000, 5'd16, bits, nb, dc);
        check("w1_bits", bits, 32'h0000_5778);
        check("w1_nbits", 32'(nb), 32'd16);
        check("w1_done_cycle", 32'(dc), 32'd17);
        check("w1_zero_runs", 32'(zero_runs), 32'd1);

        send_word(16'h0000, 5'd0, bits, nb, dc);
        check("w2_bits", bits, 32'h0);
        check("w2_nbits", 32'(nb), 32'd16);
        check("w2_done_cycle", 32'(dc), 32'd17);
        check("w2_zero_runs", 32'(zero_runs), 32'd14);

        send_word(16'hFFF8, 5'd3, bits, nb, dc);
        check("w3_nbits", 32'(nb), 32'd3);
        check("w3_bits", bits, 32'h0);
        check("w3_done_cycle", 32'(dc), 32'd4);
        check("w3_zero_runs", 32'(zero_runs), 32'd1);

        // bit_en toggling with load_valid held high through the whole transfer.
        @(negedge clk);
        load_valid = 1'b1;
        load_data = 16'h0000;
        load_len = 5'd4;
        bit_en = 1'b0;
        @(negedge clk);
        load_data = 16'h0001;
        load_len = 5'd3;
        cnt = 0;
        seen_done = 1'b0;
        c_second = -1;
        for (int c = 1; c <= 60; c++) begin
            if (ser_valid && !seen_done) cnt++;
            if (done && !seen_done) begin
                seen_done = 1'b1;
                check("tog_zero_runs_first", 32'(zero_runs), 32'd2);
                check("tog_hold_cycles", 32'(cnt), 32'd8);
            end else if (ser_valid && seen_done) begin
                c_second = c;
                check("tog_zero_runs_cleared", 32'(zero_runs), 32'd0);
                break;
            end
            bit_en = (c % 2 == 0);
            @(negedge clk);
        end
        check("tog_second_accept_cycle", 32'(c_second), 32'd11);
        load_valid = 1'b0;
        bit_en = 1'b1;
        repeat (6) @(negedge clk);

        // Reset after 5 bits of a 16-bit word.
        @(negedge clk);
        load_valid = 1'b1;
        load_data = 16'h0000;
        load_len = 5'd16;
        bit_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_zero_runs", 32'(zero_runs), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("abort_ser_valid", 32'(ser_valid), 32'd0);
        check("abort_zero_runs", 32'(zero_runs), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_word(16'hA5C3, 5'd16, bits, nb, dc);
        check("after_rst_bits", bits, 32'h0000_A5C3);
        check("after_rst_done_cycle", 32'(dc), 32'd17);
        check("after_rst_zero_runs", 32'(zero_runs), 32'd2);

        // Randomized traffic, including occasional resets and out-of-range lengths.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) load_data = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
            load_len = LEN_W'($urandom_range(0, 31));
            bit_en = ($urandom_range(0, 3) != 0);
            #2 rst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        load_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
